glay_setup_mem_responder: RTL
=============================

# glay_setup_mem_responder

Memory-side responder for the kernel setup request/response path. It accepts setup-cacheline read and write requests, serves them from a local store of `DEPTH_LINES` 512-bit lines, and returns one in-order response per request with a fixed pipeline latency. A credit-based `req_in_ready` guarantees that no response is ever dropped. It sits opposite the setup requester, either as the on-chip setup scratchpad or as the bench-side memory model.

## Interface
- `ADDR_WIDTH`, 64: byte-address width.
- `DATA_WIDTH`, 512: cacheline width; fixed at 512 (64-byte lines).
- `ID_WIDTH`, 8: request/response tag width.
- `DEPTH_LINES`, 16: number of stored lines; power of two, at least 2.
- `RESP_FIFO_DEPTH`, 4: response buffer entries; at least 2.
- `ap_clk`  in  1: clock; single clock domain.
- `ap_rst_n`  in  1: reset; asynchronous assert, active-low.
- `base_addr`  in  ADDR_WIDTH: byte address of line 0; static while `busy` is low.
- `req_in_valid`  in  1: request valid.
- `req_in_ready`  out  1: request accepted on `valid & ready`.
- `req_in_cmd`  in  1: 0 = read, 1 = write.
- `req_in_addr`  in  ADDR_WIDTH: byte address.
- `req_in_id`  in  ID_WIDTH: tag, echoed in the response.
- `req_in_data`  in  DATA_WIDTH: write data.
- `resp_out_valid`  out  1: response valid.
- `resp_out_ready`  in  1: response consumed on `valid & ready`.
- `resp_out_data`  out  DATA_WIDTH: read data; 0 for writes and errors.
- `resp_out_id`  out  ID_WIDTH: echoed tag.
- `resp_out_error`  out  1: request was out of range or misaligned.
- `busy`  out  1: high during INIT, or while any response is pipelined or buffered.

## Operation
- **States: RESET → INIT → SERVE.**
  - RESET: entered asynchronously while `ap_rst_n` = 0. Leaves on the first clock edge after deassertion.
  - INIT: writes zero to lines 0 .. `DEPTH_LINES`-1, one line per cycle, using a `$clog2(DEPTH_LINES)`-bit counter. `req_in_ready` is held 0. After the last line is written, the block moves to SERVE.
  - SERVE: steady state; it never returns to INIT except through reset.
- **Decode.**
  - `offset = req_in_addr - base_addr` (ADDR_WIDTH, modulo arithmetic).
  - `index = offset[ADDR_WIDTH-1:6]`.
  - The request is an error if `offset[5:0]` ≠ 0, or if `index` ≥ `DEPTH_LINES`. A wrapped (negative) offset always yields an out-of-range index, so it is an error.
- **Read.** Returns line `index`; `resp_out_error` = 0.
- **Write.** Stores `req_in_data` in line `index` on the accept edge. Returns a response with data = 0 and error = 0.
- **Error.** Memory is not modified. Returns data = 0 and error = 1.
- **Ordering.** Responses leave in strict acceptance order, one per accepted request.
- **Read-after-write.** A read accepted on the cycle after a write to the same line returns the new data.
- **Credit.**
  - `pipe_cnt` counts requests in the 2-stage pipeline (0..2). `fifo_cnt` counts buffered responses (0..`RESP_FIFO_DEPTH`).
  - `req_in_ready = (state == SERVE) && (pipe_cnt + fifo_cnt < RESP_FIFO_DEPTH)`, decoded from registered state only.
  - With the FIFO full and `resp_out_ready` = 0, `req_in_ready` stays 0 indefinitely with no loss.
- **Simultaneous events.**
  - A FIFO push and pop in the same cycle leaves `fifo_cnt` unchanged. This holds at full and at empty. At empty, the push goes straight to the output register.
  - An accept and a response completion in the same cycle keep the counters consistent.
- **Reset mid-operation.** All pipelined and buffered responses are discarded and all counters are cleared. Memory is re-zeroed by INIT.

## Timing
- **Reset values.**
  - `req_in_ready` = 0, `resp_out_valid` = 0, `resp_out_data` = 0, `resp_out_id` = 0, `resp_out_error` = 0.
  - `busy` = 1.
- **INIT duration.** Exactly `DEPTH_LINES` cycles. `req_in_ready` first rises `DEPTH_LINES`+1 edges after reset deassertion.
- **Latency.** A request accepted at edge E0 shows `resp_out_valid` = 1 after edge E2, provided the FIFO is empty. Otherwise the response queues behind older entries.
- **Throughput.** One request per cycle in SERVE while `resp_out_ready` = 1.
- **Registered outputs.** All outputs are driven directly from flops.
- **Response stability.** While `resp_out_valid` = 1 and `resp_out_ready` = 0, `resp_out_*` are held stable.
- **Request handshake.** `req_in_*` are sampled only on the `valid & ready` edge.

## Test plan
- **Reset/INIT.** Deassert `ap_rst_n`; hold `req_in_valid` = 1 with a read of line 3.
  - `req_in_ready` = 0 for 16 cycles, then 1.
  - The response has data = 0, error = 0, and the matching id.
- **Write/read back-to-back.**
  - `base_addr` = 0x1000. Write 0xA5.. to 0x1040 (id 1), then immediately read 0x1040 (id 2).
  - Responses appear in order: id 1 with data 0, then id 2 with 0xA5... The id 2 response appears 2 cycles after its accept.
- **Errors.** Read 0x1041, read 0x1400, and read 0x0FC0.
  - All three return error = 1 and data = 0.
  - A following read of 0x1000 shows line 0 unmodified.
- **Backpressure.** Hold `resp_out_ready` = 0 and stream 10 reads.
  - Exactly 4 are accepted; `req_in_ready` then stays 0.
  - After releasing `resp_out_ready`, all 10 responses arrive in order, with stable outputs during stalls.
- **Streaming.** 64 random reads and writes with `resp_out_ready` toggling randomly.
  - Zero loss and correct order; data matches a scoreboard.
  - `busy` falls one cycle after the last response is consumed.
- **Mid-operation reset.** Assert `ap_rst_n` = 0 with 3 responses buffered.
  - Outputs clear immediately.
  - After INIT, a read of a previously written line returns 0.

Source files
------------

// File: rtl/glay_setup_mem_responder_if.sv
// Request/response bundle between the kernel setup requester and the
// setup memory responder. The requester side is the master.
interface glay_setup_mem_responder_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 8
);
   logic                  req_in_valid;
   logic                  req_in_ready;
   logic                  req_in_cmd;
   logic [ADDR_WIDTH-1:0] req_in_addr;
   logic [ID_WIDTH-1:0]   req_in_id;
   logic [DATA_WIDTH-1:0] req_in_data;
   logic                  resp_out_valid;
   logic                  resp_out_ready;
   logic [DATA_WIDTH-1:0] resp_out_data;
   logic [ID_WIDTH-1:0]   resp_out_id;
   logic                  resp_out_error;

   modport master (
      output req_in_valid, req_in_cmd, req_in_addr, req_in_id, req_in_data, resp_out_ready,
      input  req_in_ready, resp_out_valid, resp_out_data, resp_out_id, resp_out_error
   );

   modport slave (
      input  req_in_valid, req_in_cmd, req_in_addr, req_in_id, req_in_data, resp_out_ready,
      output req_in_ready, resp_out_valid, resp_out_data, resp_out_id, resp_out_error
   );
endinterface

// File: rtl/glay_setup_mem_responder.sv
// Setup-cacheline memory responder: zeroes its line store after reset, then
// serves in-order read/write requests with a two-stage pipeline and a
// credit-guarded response FIFO so that no response is ever dropped.
module glay_setup_mem_responder #(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 512,
   parameter int ID_WIDTH        = 8,
   parameter int DEPTH_LINES     = 16,
   parameter int RESP_FIFO_DEPTH = 4
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  busy,
   glay_setup_mem_responder_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_LINES);
   localparam int PTR_W = $clog2(RESP_FIFO_DEPTH);
   localparam int CNT_W = $clog2(RESP_FIFO_DEPTH + 3);

   typedef enum logic [1:0] {ST_RESET, ST_INIT, ST_SERVE} state_e;

   state_e                state_q;
   logic [IDX_W-1:0]      initCnt_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH_LINES];

   logic                  s1Valid_q, s1Write_q, s1Err_q;
   logic [ID_WIDTH-1:0]   s1Id_q;
   logic [IDX_W-1:0]      s1Idx_q;
   logic                  s2Valid_q, s2Err_q;
   logic [ID_WIDTH-1:0]   s2Id_q;
   logic [DATA_WIDTH-1:0] s2Data_q, s2Data_d;

   logic [DATA_WIDTH-1:0] fifoData [RESP_FIFO_DEPTH];
   logic [ID_WIDTH-1:0]   fifoId   [RESP_FIFO_DEPTH];
   logic                  fifoErr  [RESP_FIFO_DEPTH];
   logic [PTR_W-1:0]      rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]      fifoCnt_q, fifoCnt_d, afterPop, pipeCnt_d;

   logic                  outValid_q, outValid_d, outErr_q, outErr_d;
   logic [DATA_WIDTH-1:0] outData_q, outData_d;
   logic [ID_WIDTH-1:0]   outId_q, outId_d;
   logic                  ready_q, busy_q;

   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      reqIdx;
   logic                  reqErr, accept, pop, push, serveNext;

   function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign bus.req_in_ready   = ready_q;
   assign bus.resp_out_valid = outValid_q;
   assign bus.resp_out_data  = outData_q;
   assign bus.resp_out_id    = outId_q;
   assign bus.resp_out_error = outErr_q;
   assign busy               = busy_q;

   // Address decode, FIFO bookkeeping and next output-register contents; the
   // output register always mirrors the FIFO head, bypassing an empty FIFO.
   always_comb begin
      offset     = bus.req_in_addr - base_addr;
      reqIdx     = offset[6 +: IDX_W];
      reqErr     = (offset[5:0] != 6'd0) || (offset[ADDR_WIDTH-1:6+IDX_W] != '0);
      accept     = ready_q && bus.req_in_valid;
      pop        = outValid_q && bus.resp_out_ready;
      push       = s2Valid_q;
      serveNext  = (state_q == ST_SERVE) ||
                   ((state_q == ST_INIT) && (initCnt_q == IDX_W'(DEPTH_LINES - 1)));
      afterPop   = fifoCnt_q - CNT_W'(pop);
      fifoCnt_d  = afterPop + CNT_W'(push);
      pipeCnt_d  = CNT_W'(accept) + CNT_W'(s1Valid_q);
      rdPtr_d    = pop  ? ptrInc(rdPtr_q) : rdPtr_q;
      wrPtr_d    = push ? ptrInc(wrPtr_q) : wrPtr_q;
      s2Data_d   = (s1Write_q || s1Err_q) ? '0 : mem[s1Idx_q];
      outValid_d = 1'b0;
      outData_d  = '0;
      outId_d    = '0;
      outErr_d   = 1'b0;
      if (afterPop != '0) begin
         outValid_d = 1'b1;
         outData_d  = fifoData[rdPtr_d];
         outId_d    = fifoId[rdPtr_d];
         outErr_d   = fifoErr[rdPtr_d];
      end else if (push) begin
         outValid_d = 1'b1;
         outData_d  = s2Data_q;
         outId_d    = s2Id_q;
         outErr_d   = s2Err_q;
      end
   end

   // Line store: zero-fill during INIT, otherwise commit in-range writes on accept.
   always_ff @(posedge ap_clk) begin
      if (state_q == ST_INIT) begin
         mem[initCnt_q] <= '0;
      end else if (accept && bus.req_in_cmd && !reqErr) begin
         mem[reqIdx] <= bus.req_in_data;
      end
   end

   // Response FIFO storage; every completed response is written, including
   // the one that simultaneously bypasses into the output register.
   always_ff @(posedge ap_clk) begin
      if (push) begin
         fifoData[wrPtr_q] <= s2Data_q;
         fifoId[wrPtr_q]   <= s2Id_q;
         fifoErr[wrPtr_q]  <= s2Err_q;
      end
   end

   // Control FSM, pipeline stages, FIFO pointers and registered outputs; the
   // credit check counts both pipeline slots so a full FIFO can never overflow.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q    <= ST_RESET;
         initCnt_q  <= '0;
         s1Valid_q  <= 1'b0;
         s1Write_q  <= 1'b0;
         s1Err_q    <= 1'b0;
         s1Id_q     <= '0;
         s1Idx_q    <= '0;
         s2Valid_q  <= 1'b0;
         s2Err_q    <= 1'b0;
         s2Id_q     <= '0;
         s2Data_q   <= '0;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         fifoCnt_q  <= '0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outId_q    <= '0;
         outErr_q   <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_RESET: begin
               state_q   <= ST_INIT;
               initCnt_q <= '0;
            end
            ST_INIT: begin
               initCnt_q <= initCnt_q + 1'b1;
               if (serveNext) state_q <= ST_SERVE;
            end
            default: state_q <= ST_SERVE;
         endcase
         s1Valid_q  <= accept;
         if (accept) begin
            s1Write_q <= bus.req_in_cmd;
            s1Err_q   <= reqErr;
            s1Id_q    <= bus.req_in_id;
            s1Idx_q   <= reqIdx;
         end
         s2Valid_q  <= s1Valid_q;
         s2Err_q    <= s1Err_q;
         s2Id_q     <= s1Id_q;
         s2Data_q   <= s2Data_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         fifoCnt_q  <= fifoCnt_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outId_q    <= outId_d;
         outErr_q   <= outErr_d;
         ready_q    <= serveNext && ((pipeCnt_d + fifoCnt_d) < CNT_W'(RESP_FIFO_DEPTH));
         busy_q     <= !serveNext || (pipeCnt_d != '0) || (fifoCnt_d != '0);
      end
   end
endmodule
